// File: rtl/arm_pkg.sv
// Shared ARM core definitions: IRQ sequencer state encoding and fixed constants.
package arm_pkg;

    typedef enum logic [2:0] {
        IRQ_IDLE   = 3'd0,
        IRQ_DRAIN  = 3'd1,
        IRQ_FLUSH  = 3'd2,
        IRQ_VECTOR = 3'd3,
        IRQ_ACTIVE = 3'd4
    } irq_state_e;

    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h0000_0018;
    localparam logic [3:0]  LR_REG_IDX         = 4'd14;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for an asynchronous level input; resets to a
// configurable idle level so inactive-low pins do not glitch out of reset.
module irq_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) chain <= {STAGES{RESET_VAL}};
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/arm_irq_sequencer.sv
// IRQ entry/exit sequencer: waits for a safe point, flushes IF/ID and ID/EX,
// writes r14 and redirects fetch, then holds irq_active until the handler returns.
module arm_irq_sequencer
    import arm_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR  = IRQ_VECTOR_DEFAULT,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nIRQ,
    input  logic        irq_mask,
    input  logic [31:0] pc_d,
    input  logic        branch_pending,
    input  logic        stall,
    input  logic        ret_valid,
    output logic        irq_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic        irq_ack,
    output logic        irq_active,
    output logic [2:0]  state_o
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    irq_state_e  state, state_n;
    logic [2:0]  cnt;
    logic [31:0] saved_lr;
    logic        sync_out;
    logic        irq_req;

    irq_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (nIRQ),
        .q     (sync_out)
    );

    assign irq_req = ~sync_out;

    always_comb begin
        state_n     = state;
        irq_flush   = 1'b0;
        pc_redirect = 1'b0;
        lr_we       = 1'b0;
        irq_ack     = 1'b0;
        irq_active  = 1'b0;
        case (state)
            IRQ_IDLE: begin
                if (irq_req && !irq_mask) state_n = IRQ_DRAIN;
            end
            IRQ_DRAIN: begin
                // Withdrawal is only honoured here; once flushing starts we are committed.
                if (!irq_req)                     state_n = IRQ_IDLE;
                else if (!branch_pending && !stall) state_n = IRQ_FLUSH;
            end
            IRQ_FLUSH: begin
                irq_flush = 1'b1;
                if (cnt == FLUSH_LAST) state_n = IRQ_VECTOR;
            end
            IRQ_VECTOR: begin
                irq_flush   = 1'b1;
                pc_redirect = 1'b1;
                lr_we       = 1'b1;
                irq_ack     = 1'b1;
                state_n     = IRQ_ACTIVE;
            end
            IRQ_ACTIVE: begin
                irq_active = 1'b1;
                if (ret_valid) state_n = IRQ_IDLE;
            end
            default: state_n = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IRQ_IDLE;
            cnt      <= 3'd0;
            saved_lr <= 32'd0;
            lr_wdata <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= (state == IRQ_FLUSH) ? cnt + 3'd1 : 3'd0;
            if (state == IRQ_DRAIN && state_n == IRQ_FLUSH) saved_lr <= pc_d + 32'd4;
            // Registered so r14 data is stable for the whole VECTOR cycle.
            lr_wdata <= (state_n == IRQ_VECTOR) ? saved_lr : 32'd0;
        end
    end

    assign pc_target = VECTOR_ADDR;
    assign state_o   = state;

endmodule

// File: tb/tb_arm_irq_sequencer.sv
// Directed and randomized bench for arm_irq_sequencer against a cycle-level behavioural model.
module tb_arm_irq_sequencer;

    localparam int          S   = 2;
    localparam int          F   = 3;
    localparam logic [31:0] VEC = 32'h0000_0018;

    logic        clk = 1'b0;
    logic        reset, nIRQ, irq_mask, branch_pending, stall, ret_valid;
    logic [31:0] pc_d;
    logic        irq_flush, pc_redirect, lr_we, irq_ack, irq_active;
    logic [31:0] pc_target, lr_wdata;
    logic [2:0]  state_o;

    arm_irq_sequencer #(.VECTOR_ADDR(VEC), .SYNC_STAGES(S), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset), .nIRQ(nIRQ), .irq_mask(irq_mask), .pc_d(pc_d),
        .branch_pending(branch_pending), .stall(stall), .ret_valid(ret_valid),
        .irq_flush(irq_flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .lr_we(lr_we), .lr_wdata(lr_wdata), .irq_ack(irq_ack), .irq_active(irq_active),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    int n_flush = 0, n_lrwe = 0, n_ack = 0, n_redir = 0;

    // Model: sync history as a delay line, phase numbered as the debug encoding,
    // flush modelled as cycles remaining.
    bit          m_sync[S];
    int          m_phase;
    int          m_left;
    logic [31:0] m_saved;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        bit req;
        @(posedge clk);
        req = !m_sync[S-1];
        if (reset) begin
            m_phase = 0; m_left = 0; m_saved = 32'd0;
            for (int i = 0; i < S; i++) m_sync[i] = 1'b1;
        end else begin
            for (int i = S-1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = nIRQ;
            case (m_phase)
                0: if (req && !irq_mask) m_phase = 1;
                1: if (!req) m_phase = 0;
                   else if (!branch_pending && !stall) begin
                       m_saved = pc_d + 32'd4; m_left = F; m_phase = 2;
                   end
                2: begin m_left--; if (m_left == 0) m_phase = 3; end
                3: m_phase = 4;
                default: if (ret_valid) m_phase = 0;
            endcase
        end
        #1;
        cyc++;
        n_flush += int'(irq_flush); n_lrwe += int'(lr_we);
        n_ack   += int'(irq_ack);   n_redir += int'(pc_redirect);
        chk("state_o",     32'(state_o),     32'(m_phase));
        chk("irq_flush",   32'(irq_flush),   32'(m_phase == 2 || m_phase == 3));
        chk("pc_redirect", 32'(pc_redirect), 32'(m_phase == 3));
        chk("lr_we",       32'(lr_we),       32'(m_phase == 3));
        chk("irq_ack",     32'(irq_ack),     32'(m_phase == 3));
        chk("irq_active",  32'(irq_active),  32'(m_phase == 4));
        chk("lr_wdata",    lr_wdata,         (m_phase == 3) ? m_saved : 32'd0);
        chk("pc_target",   pc_target,        VEC);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_counts();
        n_flush = 0; n_lrwe = 0; n_ack = 0; n_redir = 0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
        int k = 0;
        while (state_o !== s && k < lim) begin step(); k++; end
        chk(tag, 32'(state_o), 32'(s));
    endtask

    task automatic run_to_ack(input string tag, output int at, output logic [31:0] lr);
        int k = 0;
        while (irq_ack !== 1'b1 && k < 40) begin step(); k++; end
        chk(tag, 32'(irq_ack), 32'd1);
        at = cyc; lr = lr_wdata;
    endtask

    task automatic do_return();
        ret_valid = 1'b1; step(); ret_valid = 1'b0;
        chk("ret_idle", 32'(state_o), 32'd0);
    endtask

    int          n0, at;
    logic [31:0] lr, pc_save;

    initial begin
        reset = 1'b1; nIRQ = 1'b1; irq_mask = 1'b0; branch_pending = 1'b0;
        stall = 1'b0; ret_valid = 1'b0; pc_d = 32'd0;
        for (int i = 0; i < S; i++) m_sync[i] = 1'b1;
        m_phase = 0; m_left = 0; m_saved = 32'd0;
        steps(3);
        reset = 1'b0;
        cyc = 0;
        chk("rst_lr_wdata", lr_wdata, 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);

        // Basic entry and return
        pc_d = 32'h100;
        steps(10);
        nIRQ = 1'b0; n0 = cyc + 1; clr_counts();
        run_to_ack("basic_ack_seen", at, lr);
        chk("basic_ack_cycle", 32'(at), 32'(n0 + 6));
        chk("basic_lr", lr, 32'h104);
        chk("basic_flush_cnt", 32'(n_flush), 32'(F + 1));
        nIRQ = 1'b1;
        step();
        chk("basic_active", 32'(irq_active), 32'd1);
        while (cyc < 29) step();
        do_return();
        chk("basic_idle_flush", 32'(irq_flush), 32'd0);

        // Masked request
        irq_mask = 1'b1; nIRQ = 1'b0; clr_counts();
        steps(20);
        chk("mask_state", 32'(state_o), 32'd0);
        chk("mask_flush", 32'(n_flush), 32'd0);
        chk("mask_lrwe", 32'(n_lrwe + n_redir), 32'd0);
        nIRQ = 1'b1; steps(S + 1); irq_mask = 1'b0;

        // Drain hold on branch_pending
        branch_pending = 1'b1; pc_d = $urandom; nIRQ = 1'b0;
        wait_state("drain_enter", 3'd1, 10);
        steps(5);
        chk("drain_hold", 32'(state_o), 32'd1);
        pc_d = 32'h200; branch_pending = 1'b0;
        step();
        chk("drain_to_flush", 32'(state_o), 32'd2);
        pc_d = $urandom;
        run_to_ack("drain_ack_seen", at, lr);
        chk("drain_lr", lr, 32'h204);
        nIRQ = 1'b1; steps(2); do_return();

        // Withdrawal while stalled in DRAIN
        stall = 1'b1; nIRQ = 1'b0; clr_counts();
        wait_state("wd_enter", 3'd1, 10);
        nIRQ = 1'b1;
        steps(S);
        chk("wd_still_drain", 32'(state_o), 32'd1);
        step();
        chk("wd_idle", 32'(state_o), 32'd0);
        chk("wd_no_flush", 32'(n_flush), 32'd0);
        stall = 1'b0; steps(2);

        // Wrap-around, nesting ignored, back-to-back entry
        pc_d = 32'hFFFF_FFFC; nIRQ = 1'b0;
        run_to_ack("wrap_ack_seen", at, lr);
        chk("wrap_lr", lr, 32'h0);
        step(); clr_counts();
        nIRQ = 1'b1; steps(3); nIRQ = 1'b0; steps(5);
        chk("nest_active", 32'(state_o), 32'd4);
        chk("nest_no_ack", 32'(n_ack + n_flush), 32'd0);
        do_return();
        step();
        chk("b2b_drain", 32'(state_o), 32'd1);
        run_to_ack("b2b_ack_seen", at, lr);
        nIRQ = 1'b1; step(); do_return();

        // Reset during the second FLUSH cycle
        nIRQ = 1'b0; pc_save = $urandom; pc_d = pc_save; clr_counts();
        wait_state("rst_flush_enter", 3'd2, 10);
        step();
        chk("rst_flush_second", 32'(state_o), 32'd2);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_mid_state", 32'(state_o), 32'd0);
        chk("rst_mid_flush", 32'(irq_flush), 32'd0);
        nIRQ = 1'b1; steps(6);
        chk("rst_mid_no_lrwe", 32'(n_lrwe + n_redir), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) nIRQ = ~nIRQ;
            irq_mask       = ($urandom_range(0, 5) == 0);
            branch_pending = ($urandom_range(0, 2) == 0);
            stall          = ($urandom_range(0, 2) == 0);
            ret_valid      = ($urandom_range(0, 9) == 0);
            reset          = ($urandom_range(0, 199) == 0);
            pc_d           = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
